// File: rtl/fu_exec_unit.sv
// -----------------------------------------------------------------------------
// fu_exec_unit
//
// One execution lane that sits downstream of a reservation-station issue
// port. It captures one issued op, computes the result in one cycle, or in
// MUL_LATENCY cycles for a multiply. It then holds the result on the
// writeback/wakeup port until the result-bus arbiter grants it.
//
// Parameters
//   MUL_LATENCY  cycles from capture to wb_valid for MUL (1..15).
//                A value of 1 makes MUL behave like any single-cycle op.
//
// Optional feature (compile-time macro FU_FAST_RETIRE_EN)
//   When the macro is defined, a new op may be captured on the same edge
//   that the arbiter grants the pending result. Single-cycle ops can then
//   issue back to back. When the macro is undefined, the lane must return to
//   IDLE before it accepts another op.
//
// Ports
//   clk            rising-edge clock
//   reset_n        asynchronous active-low reset
//   issue_valid    issue strobe from the reservation station
//   issue_is_LS    load/store address computation (rs1 + imm)
//   issue_alusrc   1: operand B = imm, 0: operand B = rs2_val
//   issue_alu_type 4-bit ALU control code
//   issue_rd_tag   destination physical register tag
//   issue_rob_num  ROB entry number
//   issue_rs1_val  operand A
//   issue_rs2_val  rs2 value (also the store data for LS ops)
//   issue_imm      immediate
//   fu_ready       lane can accept an issue at the next edge
//   wb_valid       result pending on the writeback port
//   wb_tag         rd tag of the pending result
//   wb_val         result value
//   wb_rob_num     ROB entry of the pending result
//   wb_is_LS       result is a load/store address
//   wb_st_data     captured rs2_val; meaningful only when wb_is_LS = 1
//   wb_grant       arbiter accepts the writeback at this edge
// -----------------------------------------------------------------------------
module fu_exec_unit #(
    parameter int MUL_LATENCY = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        issue_valid,
    input  logic        issue_is_LS,
    input  logic        issue_alusrc,
    input  logic [3:0]  issue_alu_type,
    input  logic [5:0]  issue_rd_tag,
    input  logic [5:0]  issue_rob_num,
    input  logic [31:0] issue_rs1_val,
    input  logic [31:0] issue_rs2_val,
    input  logic [31:0] issue_imm,
    output logic        fu_ready,
    output logic        wb_valid,
    output logic [5:0]  wb_tag,
    output logic [31:0] wb_val,
    output logic [5:0]  wb_rob_num,
    output logic        wb_is_LS,
    output logic [31:0] wb_st_data,
    input  logic        wb_grant
);

    // ALU control codes
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SLL  = 4'd6;
    localparam logic [3:0] ALU_SRL  = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd8;
    localparam logic [3:0] ALU_SLT  = 4'd9;
    localparam logic [3:0] ALU_SLTU = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;
    localparam logic [3:0] ALU_MUL  = 4'd12;

    // A multi-cycle multiply exists only when the latency exceeds one
    // cycle. Otherwise MUL takes the single-cycle path like every other op.
    localparam bit         MUL_MULTI  = (MUL_LATENCY > 1);
    localparam logic [3:0] MUL_COUNT0 = 4'(MUL_LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    state_t      state_reg,      state_next;
    logic [3:0]  count_reg,      count_next;
    logic [31:0] opa_reg,        opa_next;
    logic [31:0] opb_reg,        opb_next;
    logic        wb_valid_reg,   wb_valid_next;
    logic [5:0]  wb_tag_reg,     wb_tag_next;
    logic [31:0] wb_val_reg,     wb_val_next;
    logic [5:0]  wb_rob_reg,     wb_rob_next;
    logic        wb_is_ls_reg,   wb_is_ls_next;
    logic [31:0] wb_st_data_reg, wb_st_data_next;

    // -------------------------------------------------------------------------
    // Single-cycle ALU
    // -------------------------------------------------------------------------
    function automatic logic [31:0] alu_calc(
        input logic [3:0]  op,
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [31:0] imm
    );
        logic [31:0] r;
        r = 32'd0;
        case (op)
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_XOR:  r = a ^ b;
            ALU_SLL:  r = a << b[4:0];
            ALU_SRL:  r = a >> b[4:0];
            ALU_SRA:  r = $unsigned($signed(a) >>> b[4:0]);
            ALU_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: r = (a < b) ? 32'd1 : 32'd0;
            ALU_LUI:  r = imm;
            ALU_MUL:  r = a * b;
            default:  r = 32'd0;
        endcase
        return r;
    endfunction

    logic [31:0] op_b;
    logic [31:0] single_result;
    logic        issue_long_mul;
    logic        can_accept;
    logic        capture;

    assign op_b = issue_alusrc ? issue_imm : issue_rs2_val;

    // A load/store op overrides the ALU code with an address add.
    assign single_result = issue_is_LS ? (issue_rs1_val + issue_imm)
                                       : alu_calc(issue_alu_type, issue_rs1_val,
                                                  op_b, issue_imm);

    assign issue_long_mul = MUL_MULTI && !issue_is_LS && (issue_alu_type == ALU_MUL);

`ifdef FU_FAST_RETIRE_EN
    // The slot also frees up on the edge where the pending result is
    // granted, so a new op can be captured on that same edge.
    assign can_accept = (state_reg == ST_IDLE) ||
                        ((state_reg == ST_DONE) && wb_grant);
`else
    assign can_accept = (state_reg == ST_IDLE);
`endif

    // fu_ready drops in the same cycle an issue is presented, so the
    // reservation station cannot place a second op into this lane.
    assign fu_ready = can_accept && !issue_valid;
    assign capture  = can_accept && issue_valid;

    // -------------------------------------------------------------------------
    // Next-state and datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        count_next      = count_reg;
        opa_next        = opa_reg;
        opb_next        = opb_reg;
        wb_valid_next   = wb_valid_reg;
        wb_tag_next     = wb_tag_reg;
        wb_val_next     = wb_val_reg;
        wb_rob_next     = wb_rob_reg;
        wb_is_ls_next   = wb_is_ls_reg;
        wb_st_data_next = wb_st_data_reg;

        case (state_reg)
            ST_BUSY: begin
                if (count_reg == 4'd1) begin
                    wb_val_next   = opa_reg * opb_reg;
                    wb_valid_next = 1'b1;
                    count_next    = 4'd0;
                    state_next    = ST_DONE;
                end else begin
                    count_next = count_reg - 4'd1;
                end
            end
            ST_DONE: begin
                if (wb_grant) begin
                    wb_valid_next = 1'b0;
                    state_next    = ST_IDLE;
                end
            end
            default: ;
        endcase

        // Capture takes priority over the DONE retirement above. With fast
        // retire, this replaces the granted result in the same edge.
        if (capture) begin
            wb_tag_next     = issue_rd_tag;
            wb_rob_next     = issue_rob_num;
            wb_is_ls_next   = issue_is_LS;
            wb_st_data_next = issue_rs2_val;
            if (issue_long_mul) begin
                opa_next      = issue_rs1_val;
                opb_next      = op_b;
                count_next    = MUL_COUNT0;
                wb_valid_next = 1'b0;
                state_next    = ST_BUSY;
            end else begin
                wb_val_next   = single_result;
                wb_valid_next = 1'b1;
                state_next    = ST_DONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= ST_IDLE;
            count_reg      <= 4'd0;
            opa_reg        <= 32'd0;
            opb_reg        <= 32'd0;
            wb_valid_reg   <= 1'b0;
            wb_tag_reg     <= 6'd0;
            wb_val_reg     <= 32'd0;
            wb_rob_reg     <= 6'd0;
            wb_is_ls_reg   <= 1'b0;
            wb_st_data_reg <= 32'd0;
        end else begin
            state_reg      <= state_next;
            count_reg      <= count_next;
            opa_reg        <= opa_next;
            opb_reg        <= opb_next;
            wb_valid_reg   <= wb_valid_next;
            wb_tag_reg     <= wb_tag_next;
            wb_val_reg     <= wb_val_next;
            wb_rob_reg     <= wb_rob_next;
            wb_is_ls_reg   <= wb_is_ls_next;
            wb_st_data_reg <= wb_st_data_next;
        end
    end

    assign wb_valid   = wb_valid_reg;
    assign wb_tag     = wb_tag_reg;
    assign wb_val     = wb_val_reg;
    assign wb_rob_num = wb_rob_reg;
    assign wb_is_LS   = wb_is_ls_reg;
    assign wb_st_data = wb_st_data_reg;

endmodule
